seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the counter's 7-segment display. It takes a packed BCD value through a valid/ready handshake and holds it in a shadow register that updates only at frame boundaries, so no digit tears. It then cycles the shared segment bus across up to four digit positions, with a blanking gap between digits to prevent ghosting. It drives the digit-select index, the one-hot digit enable and the BCD nibble to the downstream 7-segment decoder.

---
 rtl/seg_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous shadow register.
// Optional leading-zero blanking: define SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 2,
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned BLANK_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [1:0]  select,
    output logic [3:0]  digit_en,
    output logic [3:0]  bcd,
    output logic        frame_tick
);

    localparam int unsigned TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYCLES);
    localparam logic [TW-1:0] DWELL_END = TW'(DWELL_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [1:0]    LAST_SEL  = 2'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [1:0]    sel_nx;
    logic [15:0]   shadow, shadow_nx;
    logic [15:0]   pending, pending_nx;
    logic          ready_nx;
    logic          boundary, accept, lit;
    logic [3:0]    en_nx, bcd_nx;
    logic          tick_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            timer      <= '0;
            select     <= '0;
            digit_en   <= '0;
            bcd        <= '0;
            frame_tick <= 1'b0;
            data_ready <= 1'b1;
            shadow     <= '0;
            pending    <= '0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            select     <= sel_nx;
            digit_en   <= en_nx;
            bcd        <= bcd_nx;
            frame_tick <= tick_nx;
            data_ready <= ready_nx;
            shadow     <= shadow_nx;
            pending    <= pending_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        sel_nx     = select;
        shadow_nx  = shadow;
        pending_nx = pending;
        ready_nx   = data_ready;
        en_nx      = '0;
        lit        = 1'b1;

        boundary = (state == SHOW) && (timer == DWELL_END) && (select == LAST_SEL);
        accept   = data_valid && data_ready;

        // Timer restarts at 1 on entry; reset leaves it at 0 so the first
        // BLANK begins on the first edge after reset release.
        case (state)
            BLANK: begin
                if (timer == BLANK_END) begin
                    state_nx = SHOW;
                    timer_nx = TIMER_ONE;
                end else begin
                    timer_nx = timer + TIMER_ONE;
                end
            end
            SHOW: begin
                if (timer == DWELL_END) begin
                    state_nx = BLANK;
                    timer_nx = TIMER_ONE;
                    sel_nx   = (select == LAST_SEL) ? 2'd0 : select + 2'd1;
                end else begin
                    timer_nx = timer + TIMER_ONE;
                end
            end
            default: begin
                state_nx = BLANK;
                timer_nx = '0;
            end
        endcase

        // data_ready low doubles as the pending-full flag.
        if (accept && boundary) begin
            shadow_nx = data_in;
        end else begin
            if (boundary && !data_ready) begin
                shadow_nx = pending;
                ready_nx  = 1'b1;
            end
            if (accept) begin
                pending_nx = data_in;
                ready_nx   = 1'b0;
            end
        end

        bcd_nx = shadow_nx[{sel_nx, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
        lit = (sel_nx == 2'd0);
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            if ((i >= 32'(sel_nx)) && (shadow_nx[4*i +: 4] != 4'd0))
                lit = 1'b1;
        end
`else
        lit = 1'b1;
`endif

        if (state_nx == SHOW && lit)
            en_nx = 4'b0001 << sel_nx;

        tick_nx = (state_nx == SHOW) && (timer_nx == DWELL_END) && (sel_nx == LAST_SEL);
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed table-driven bench for seg_scan_ctrl (NUM_DIGITS=2, DWELL=4, BLANK=1).
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [1:0]  select;
    logic [3:0]  digit_en;
    logic [3:0]  bcd;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    seg_scan_ctrl #(.NUM_DIGITS(2), .DWELL_CYCLES(4), .BLANK_CYCLES(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .select     (select),
        .digit_en   (digit_en),
        .bcd        (bcd),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] din;
        logic [3:0]  en;
        logic [1:0]  sel;
        logic [3:0]  bcd;
        logic        tick;
        logic        ready;
    } vec_t;

    vec_t tbl [1:40];

    task automatic check(input string name, input int cyc, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int cyc, input logic [3:0] en, input logic [1:0] sel,
                             input logic [3:0] b, input logic tick, input logic rdy);
        check("digit_en",   cyc, {12'd0, digit_en},   {12'd0, en});
        check("select",     cyc, {14'd0, select},     {14'd0, sel});
        check("bcd",        cyc, {12'd0, bcd},        {12'd0, b});
        check("frame_tick", cyc, {15'd0, frame_tick}, {15'd0, tick});
        check("data_ready", cyc, {15'd0, data_ready}, {15'd0, rdy});
    endtask

    initial begin
        // Expected scan pattern per 10-cycle frame: blank, 4x digit0, blank, 4x digit1.
        for (int c = 1; c <= 40; c++) begin
            int p;
            p = (c - 1) % 10;
            tbl[c].valid = 1'b0;
            tbl[c].din   = 16'h0000;
            tbl[c].sel   = (p < 5) ? 2'd0 : 2'd1;
            tbl[c].en    = (p == 0 || p == 5) ? 4'b0000 : ((p < 5) ? 4'b0001 : 4'b0010);
            tbl[c].tick  = (p == 9);
            tbl[c].ready = !((c >= 13 && c <= 20) || (c >= 33));
            if (c <= 20)      tbl[c].bcd = 4'd0;
            else if (c <= 30) tbl[c].bcd = (p < 5) ? 4'd9 : 4'd1;
            else              tbl[c].bcd = (p < 5) ? 4'd2 : 4'd1;
`ifdef SEG_SCAN_LZB_EN
            if (c <= 20 && p > 5) tbl[c].en = 4'b0000;
`endif
        end
        tbl[13].valid = 1'b1; tbl[13].din = 16'h0019;
        tbl[15].valid = 1'b1; tbl[15].din = 16'h0007;
        tbl[31].valid = 1'b1; tbl[31].din = 16'h0012;
        tbl[33].valid = 1'b1; tbl[33].din = 16'h0005;

        rst_n      = 1'b0;
        data_valid = 1'b0;
        data_in    = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_all(0, 4'b0000, 2'd0, 4'd0, 1'b0, 1'b1);
        rst_n = 1'b1;

        for (int c = 1; c <= 40; c++) begin
            data_valid = tbl[c].valid;
            data_in    = tbl[c].din;
            step();
            data_valid = 1'b0;
            check_all(c, tbl[c].en, tbl[c].sel, tbl[c].bcd, tbl[c].tick, tbl[c].ready);
        end

        // Frame after loading 0005: digit 1 is zero, blanked only with LZB.
        step(); check_all(41, 4'b0000, 2'd0, 4'd5, 1'b0, 1'b1);
        step(); check_all(42, 4'b0001, 2'd0, 4'd5, 1'b0, 1'b1);
        repeat (4) step();
        check_all(46, 4'b0000, 2'd1, 4'd0, 1'b0, 1'b1);
        step();
`ifdef SEG_SCAN_LZB_EN
        check_all(47, 4'b0000, 2'd1, 4'd0, 1'b0, 1'b1);
`else
        check_all(47, 4'b0010, 2'd1, 4'd0, 1'b0, 1'b1);
`endif
        repeat (3) step();
        check("frame_tick", 50, {15'd0, frame_tick}, 16'd1);

        // Accept a value, then reset during SHOW of digit 1 while it is pending.
        repeat (2) step();
        data_valid = 1'b1; data_in = 16'h0033;
        step();
        data_valid = 1'b0;
        check("data_ready", 53, {15'd0, data_ready}, 16'd0);
        repeat (4) step();
        check("select", 57, {14'd0, select}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all(57, 4'b0000, 2'd0, 4'd0, 1'b0, 1'b1);
        step();
        rst_n = 1'b1;
        step(); check_all(1, 4'b0000, 2'd0, 4'd0, 1'b0, 1'b1);
        step(); check_all(2, 4'b0001, 2'd0, 4'd0, 1'b0, 1'b1);
        repeat (8) step();
        check("frame_tick", 10, {15'd0, frame_tick}, 16'd1);
        step(); check_all(11, 4'b0000, 2'd0, 4'd0, 1'b0, 1'b1);
        step(); check_all(12, 4'b0001, 2'd0, 4'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
